// File: rtl/fmap_pad_pkg.sv
// Shared encodings and helpers for the feature-map padding stream.
// Imported by pad_pos_counter and fmap_pad_stream.
package fmap_pad_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef enum logic {
        ZERO  = 1'b0,
        CONST = 1'b1
    } pad_mode_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pad_pos_counter.sv
// Raster position counter over the padded output frame.
// col wraps at OUT_W-1 and carries into row; row wraps at OUT_H-1.
module pad_pos_counter
    import fmap_pad_pkg::*;
#(
    parameter int unsigned OUT_W = 30,
    parameter int unsigned OUT_H = 30,
    localparam int unsigned CW = (clog2(OUT_W) > 0) ? clog2(OUT_W) : 1,
    localparam int unsigned RW = (clog2(OUT_H) > 0) ? clog2(OUT_H) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last_col,
    output logic          last_pix
);

    logic last_row;

    assign last_col = (col == CW'(OUT_W - 1));
    assign last_row = (row == RW'(OUT_H - 1));
    assign last_pix = last_col && last_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fmap_pad_stream.sv
// Streams a FMAP_W x FMAP_H frame out as a padded OUT_W x OUT_H frame,
// filling border positions with zero or a captured constant.
module fmap_pad_stream
    import fmap_pad_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CH         = 1,
    parameter int FMAP_W     = 28,
    parameter int FMAP_H     = 28,
    parameter int PAD_X      = 1,
    parameter int PAD_Y      = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     pad_mode,
    input  logic [CH*DATA_WIDTH-1:0] pad_value,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [CH*DATA_WIDTH-1:0] s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CH*DATA_WIDTH-1:0] m_data,
    output logic                     m_sof,
    output logic                     m_eol,
    output logic                     m_eof,
    output logic                     busy,
    output logic                     done
);

    localparam int BW    = CH * DATA_WIDTH;
    localparam int OUT_W = FMAP_W + 2 * PAD_X;
    localparam int OUT_H = FMAP_H + 2 * PAD_Y;
    localparam int CW    = (clog2(OUT_W) > 0) ? clog2(OUT_W) : 1;
    localparam int RW    = (clog2(OUT_H) > 0) ? clog2(OUT_H) : 1;

    state_t          state;
    state_t          state_nx;
    pad_mode_t       mode_q;
    logic [BW-1:0]   pad_q;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic            last_col;
    logic            last_pix;
    logic            interior;
    logic            out_free;
    logic            load;
    logic            done_nx;
    logic            start_ok;
    logic            pos_clr;
    logic [BW-1:0]   fill;

    pad_pos_counter #(
        .OUT_W (OUT_W),
        .OUT_H (OUT_H)
    ) u_pos (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (load),
        .clr      (pos_clr),
        .row      (row),
        .col      (col),
        .last_col (last_col),
        .last_pix (last_pix)
    );

    assign interior = (int'(row) >= PAD_Y) && (int'(row) < PAD_Y + FMAP_H)
                   && (int'(col) >= PAD_X) && (int'(col) < PAD_X + FMAP_W);
    assign out_free = !m_valid || m_ready;
    assign start_ok = (state == IDLE) && start && !clear;
    assign pos_clr  = clear || start_ok;
    assign busy     = (state != IDLE);
    assign fill     = interior ? s_data : ((mode_q == CONST) ? pad_q : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // clear overrides every transition and suppresses the load and done pulse.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        s_ready  = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                s_ready = interior && out_free;
                load    = out_free && (!interior || s_valid);
                if (load && last_pix) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (m_valid && m_ready) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (clear) begin
            state_nx = IDLE;
            load     = 1'b0;
            done_nx  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= ZERO;
            pad_q   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= done_nx;
            if (start_ok) begin
                mode_q <= pad_mode_t'(pad_mode);
                pad_q  <= pad_value;
            end
            if (clear) begin
                m_valid <= 1'b0;
                m_sof   <= 1'b0;
                m_eol   <= 1'b0;
                m_eof   <= 1'b0;
            end else if (load) begin
                m_valid <= 1'b1;
                m_data  <= fill;
                m_sof   <= (row == '0) && (col == '0);
                m_eol   <= last_col;
                m_eof   <= last_pix;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fmap_pad_stream.sv
// Randomised bench for fmap_pad_stream: a position-based frame model checks
// every accepted output beat, plus a directed check of a zero-pad build.
module tb_fmap_pad_stream;

    localparam int FW = 3;
    localparam int FH = 2;
    localparam int PX = 1;
    localparam int PY = 1;
    localparam int OW = FW + 2 * PX;
    localparam int OH = FH + 2 * PY;
    localparam int NB = OW * OH;
    localparam int NI = FW * FH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        pad_mode = 1'b0;
    logic [15:0] pad_value = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        m_sof, m_eol, m_eof, busy, done;

    logic        z_start = 1'b0;
    logic        z_s_valid = 1'b0;
    logic        z_s_ready;
    logic [15:0] z_s_data = '0;
    logic        z_m_valid;
    logic        z_m_ready = 1'b1;
    logic [15:0] z_m_data;
    logic        z_m_sof, z_m_eol, z_m_eof, z_busy, z_done;

    always #5 clk = ~clk;

    fmap_pad_stream #(
        .DATA_WIDTH (16), .CH (1), .FMAP_W (FW), .FMAP_H (FH), .PAD_X (PX), .PAD_Y (PY)
    ) dut (
        .clk (clk), .rst_n (rst_n), .clear (clear), .start (start),
        .pad_mode (pad_mode), .pad_value (pad_value),
        .s_valid (s_valid), .s_ready (s_ready), .s_data (s_data),
        .m_valid (m_valid), .m_ready (m_ready), .m_data (m_data),
        .m_sof (m_sof), .m_eol (m_eol), .m_eof (m_eof),
        .busy (busy), .done (done)
    );

    fmap_pad_stream #(
        .DATA_WIDTH (16), .CH (1), .FMAP_W (FW), .FMAP_H (FH), .PAD_X (0), .PAD_Y (0)
    ) dut_z (
        .clk (clk), .rst_n (rst_n), .clear (clear), .start (z_start),
        .pad_mode (pad_mode), .pad_value (pad_value),
        .s_valid (z_s_valid), .s_ready (z_s_ready), .s_data (z_s_data),
        .m_valid (z_m_valid), .m_ready (z_m_ready), .m_data (z_m_data),
        .m_sof (z_m_sof), .m_eol (z_m_eol), .m_eof (z_m_eof),
        .busy (z_busy), .done (z_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endfunction

    // Frame description shared with the model
    logic [15:0] in_vals [NI];
    logic        cur_mode = 1'b0;
    logic [15:0] cur_pad = '0;

    function automatic bit is_interior(input int p);
        int r, c;
        if (p < 0 || p >= NB) return 1'b0;
        r = p / OW;
        c = p % OW;
        return (r >= PY) && (r < PY + FH) && (c >= PX) && (c < PX + FW);
    endfunction

    function automatic logic [15:0] model_data(input int p);
        int r, c;
        r = p / OW;
        c = p % OW;
        if (is_interior(p)) return in_vals[(r - PY) * FW + (c - PX)];
        return cur_mode ? cur_pad : 16'h0000;
    endfunction

    // Compare process state
    int          out_pos = 0;
    int          frames_done = 0;
    logic        exp_done = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_clear = 1'b0;
    logic [15:0] prev_data = '0;
    logic [15:0] got_data [NB];
    logic        got_eol [NB];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_flags", {m_sof, m_eol, m_eof}, 0);
            chk("rst_busy_done", {busy, done}, 0);
            chk("rst_s_ready", s_ready, 0);
            out_pos = 0;
            exp_done = 1'b0;
            prev_stall = 1'b0;
            prev_clear = 1'b0;
        end else begin
            chk("done", done, exp_done);
            exp_done = 1'b0;
            if (prev_stall && !prev_clear) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
            end
            if (!m_valid && !busy) out_pos = 0;
            if (s_ready) chk("s_ready_at_pad", is_interior(out_pos + int'(m_valid)), 1);
            if (m_valid && m_ready) begin
                chk("beat_data", m_data, model_data(out_pos));
                chk("beat_sof", m_sof, out_pos == 0);
                chk("beat_eol", m_eol, (out_pos % OW) == OW - 1);
                chk("beat_eof", m_eof, out_pos == NB - 1);
                got_data[out_pos] = m_data;
                got_eol[out_pos] = m_eol;
                if (out_pos == NB - 1) begin
                    if (!clear) begin
                        exp_done = 1'b1;
                        frames_done++;
                    end
                    out_pos = 0;
                end else begin
                    out_pos++;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_clear = clear;
            prev_data = m_data;
        end
    end

    task automatic run_frame(input logic mode, input logic [15:0] pv, input bit stall,
                             input bit rand_valid, input int abort_beat, input int rst_beat,
                             input bit late_start);
        int beats, cyc, first, last, f0, in_idx;
        bit s_fire, m_fire;
        beats = 0; cyc = 0; first = -1; last = -1; in_idx = 0;
        f0 = frames_done;
        cur_mode = mode;
        cur_pad = pv;
        pad_mode = mode;
        pad_value = pv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pad_mode = ~mode;
        pad_value = 16'($urandom);
        while (frames_done == f0 && cyc < 300) begin
            s_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data = (in_idx < NI) ? in_vals[in_idx] : 16'hDEAD;
            m_ready = stall ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
            s_fire = s_valid && s_ready;
            m_fire = m_valid && m_ready;
            @(posedge clk); #1;
            if (s_fire) in_idx++;
            if (m_fire) begin
                if (first < 0) first = cyc;
                last = cyc;
                beats++;
            end
            cyc++;
            if (late_start) start = (beats == NB - 1);
            if (m_fire && abort_beat > 0 && beats == abort_beat) begin
                clear = 1'b1;
                s_valid = 1'b0;
                @(posedge clk); #1;
                clear = 1'b0;
                chk("clear_m_valid", m_valid, 0);
                chk("clear_busy", busy, 0);
                repeat (3) @(posedge clk);
                #1;
                chk("clear_no_done", frames_done, f0);
                return;
            end
            if (m_fire && rst_beat > 0 && beats == rst_beat) begin
                #2 rst_n = 1'b0;
                #1;
                chk("async_rst_outs", {m_valid, m_sof, m_eol, m_eof, busy, done, s_ready}, 0);
                chk("async_rst_data", m_data, 0);
                s_valid = 1'b0;
                @(posedge clk);
                @(posedge clk); #1;
                rst_n = 1'b1;
                chk("post_rst_busy", busy, 0);
                return;
            end
        end
        start = 1'b0;
        s_valid = 1'b0;
        chk("frame_complete", frames_done, f0 + 1);
        chk("frame_beats", beats, NB);
        if (!stall && !rand_valid) chk("throughput", last - first + 1, NB);
        if (late_start) begin
            repeat (3) @(posedge clk);
            #1;
            chk("start_in_drain_ignored", busy, 0);
        end
    endtask

    initial begin
        int pads;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("idle_busy", busy, 0);
        chk("idle_s_ready", s_ready, 0);
        chk("idle_m_valid", m_valid, 0);

        for (int i = 0; i < NI; i++) in_vals[i] = 16'(i + 1);
        run_frame(1'b0, 16'h0000, 1'b0, 1'b0, 0, 0, 1'b1);
        chk("lit_zero_pad0", got_data[0], 16'h0000);
        chk("lit_in1", got_data[6], 16'h0001);
        chk("lit_in3", got_data[8], 16'h0003);
        chk("lit_in4", got_data[11], 16'h0004);
        chk("lit_in6", got_data[13], 16'h0006);
        chk("lit_zero_last", got_data[19], 16'h0000);
        chk("lit_eol_pattern", {got_eol[4], got_eol[9], got_eol[14], got_eol[19], got_eol[3]}, 5'b11110);

        run_frame(1'b1, 16'hABCD, 1'b0, 1'b0, 0, 0, 1'b0);
        pads = 0;
        for (int i = 0; i < NB; i++) if (got_data[i] == 16'hABCD) pads++;
        chk("const_pad_count", pads, 14);
        chk("lit_const_first", got_data[0], 16'hABCD);
        chk("lit_const_in2", got_data[7], 16'h0002);

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NI; i++) in_vals[i] = 16'($urandom);
            run_frame(1'($urandom_range(0, 1)), 16'($urandom), 1'b1, 1'b1, 0, 0, 1'b0);
        end

        for (int i = 0; i < NI; i++) in_vals[i] = 16'(i + 1);
        run_frame(1'b0, 16'h0000, 1'b0, 1'b0, 8, 0, 1'b0);
        run_frame(1'b0, 16'h0000, 1'b0, 1'b0, 0, 0, 1'b0);

        run_frame(1'b1, 16'h1234, 1'b1, 1'b1, 0, 12, 1'b0);
        run_frame(1'b1, 16'h1234, 1'b0, 1'b1, 0, 0, 1'b0);

        z_start = 1'b1;
        @(posedge clk); #1;
        z_start = 1'b0;
        z_s_valid = 1'b1;
        for (int k = 1; k <= NI; k++) begin
            z_s_data = 16'(k);
            @(negedge clk);
            chk("z_s_ready", z_s_ready, 1);
            if (k > 1) begin
                chk("z_m_valid", z_m_valid, 1);
                chk("z_latency_data", z_m_data, k - 1);
                chk("z_sof", z_m_sof, k == 2);
                chk("z_eol", z_m_eol, ((k - 1) % FW) == 0);
                chk("z_eof", z_m_eof, 0);
            end
            @(posedge clk); #1;
        end
        z_s_valid = 1'b0;
        @(negedge clk);
        chk("z_last_data", z_m_data, NI);
        chk("z_last_flags", {z_m_valid, z_m_eol, z_m_eof}, 3'b111);
        chk("z_drain_s_ready", z_s_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("z_done", z_done, 1);
        chk("z_idle", {z_m_valid, z_busy}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fmap_pad_stream.md
FMAP_PAD_STREAM -- requirements
Module: fmap_pad_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning bits per channel sample.
REQ-002 SHALL have parameter CH, default 1, meaning channels packed per beat; the bus width is CH*DATA_WIDTH.
REQ-003 SHALL have parameters FMAP_W and FMAP_H, both default 28, meaning the input frame width and height.
REQ-004 SHALL have parameters PAD_X and PAD_Y, both default 1, meaning the pad columns per side and pad rows per side; 0 is legal.
REQ-005 SHALL expose ports, in this order:
- clk  in  1  clock; one clock domain only.
- rst_n  in  1  reset; asynchronous assert, active-low.
- clear  in  1  synchronous abort.
- start  in  1  begin a frame.
- pad_mode  in  1  fill source: 0 = zero, 1 = constant.
- pad_value  in  CH*DATA_WIDTH  constant fill value.
- s_valid / s_ready  in / out  1  input handshake.
- s_data  in  CH*DATA_WIDTH  raw pixel.
- m_valid / m_ready  out / in  1  output handshake.
- m_data  out  CH*DATA_WIDTH  padded pixel.
- m_sof / m_eol / m_eof  out  1  first beat of frame / last beat of row / last beat of frame.
- busy  out  1  frame in progress.
- done  out  1  one-cycle end-of-frame pulse.

Function
REQ-006 SHALL emit OUT_W = FMAP_W + 2*PAD_X by OUT_H = FMAP_H + 2*PAD_Y beats per frame, in raster order.
REQ-007 Position (row, col) SHALL be interior iff PAD_Y ≤ row < PAD_Y + FMAP_H and PAD_X ≤ col < PAD_X + FMAP_W; all other positions are pad positions.
REQ-008 The FSM SHALL have states IDLE, RUN and DRAIN; reset state is IDLE.
REQ-009 In IDLE, start SHALL:
- capture pad_mode and pad_value;
- clear row and col;
- enter RUN.
REQ-010 start SHALL be ignored outside IDLE.
REQ-011 The output register SHALL load when state == RUN and (!m_valid || m_ready).
REQ-012 At an interior position, a load SHALL additionally require s_valid.
REQ-013 At a pad position, a load SHALL not depend on s_valid, and the loaded data SHALL be zero (mode 0) or the captured pad_value (mode 1).
REQ-014 s_ready SHALL be high exactly when state == RUN, the position is interior and (!m_valid || m_ready), i.e. combinational from m_ready.
REQ-015 Latency SHALL be one cycle from an s_valid && s_ready handshake to the beat appearing on m_data.
REQ-016 Sustained throughput SHALL be 1 beat/cycle when m_ready stays high.
REQ-017 m_valid and m_data SHALL hold stable while m_valid && !m_ready.
REQ-018 On each load, col SHALL increment.
REQ-019 col SHALL wrap from OUT_W-1 to 0, incrementing row on the wrap.
REQ-020 Loading position (OUT_H-1, OUT_W-1) SHALL move the FSM RUN → DRAIN.
REQ-021 In DRAIN, the m_valid && m_ready handshake SHALL:
- pulse done for one cycle;
- move the FSM to IDLE;
- drop m_valid unless a new frame has loaded.
REQ-022 m_sof SHALL be high with the beat at (0,0), m_eol with col == OUT_W-1, and m_eof with (OUT_H-1, OUT_W-1); all three are registered alongside m_data.
REQ-023 busy SHALL equal (state != IDLE).
REQ-024 A start in the same cycle as the final DRAIN handshake SHALL be ignored; a new frame needs start while in IDLE.
REQ-025 clear SHALL have priority over start and every handshake, and SHALL:
- force IDLE;
- drop m_valid;
- zero row and col;
- suppress done.
REQ-026 With PAD_X = PAD_Y = 0, the block SHALL be a one-stage registered pass-through of FMAP_W*FMAP_H beats.
REQ-027 Counter widths SHALL be clog2(OUT_W) and clog2(OUT_H) bits, and no counter may overflow.

Reset
REQ-028 rst_n low SHALL asynchronously force:
- state = IDLE;
- row = col = 0;
- m_valid, m_sof, m_eol, m_eof, done and busy = 0;
- m_data and the captured pad_value = 0;
- the captured pad_mode = 0.
REQ-029 s_ready SHALL be 0 while in reset.
REQ-030 Reset deassertion mid-frame SHALL resume in IDLE with no partial frame output.

Structure
REQ-031 A shared package fmap_pad_pkg SHALL hold:
- the state encoding (IDLE/RUN/DRAIN);
- the pad-mode encoding (ZERO = 0, CONST = 1);
- the clog2 function.
REQ-032 Row and column counting SHALL live in sub-module pad_pos_counter. It is parametrised by OUT_W and OUT_H, with inputs inc and clr and outputs row, col, last_col and last_pix.

Verification (FMAP_W=3, FMAP_H=2, PAD_X=1, PAD_Y=1, CH=1)
REQ-033 Zero mode, inputs 1..6, m_ready held 1:
- 20 beats out; rows [0 0 0 0 0], [0 1 2 3 0], [0 4 5 6 0], [0 0 0 0 0];
- m_eol on beats 5, 10, 15, 20; m_eof and the done pulse on beat 20.
REQ-034 Constant mode, pad_value = 0xABCD: all 14 pad beats SHALL be 0xABCD and the interior beats 1..6.
REQ-035 With m_ready toggling 1,0,1,0… and s_valid random: no beat is lost or duplicated, m_data holds while stalled, and s_ready stays 0 at pad positions.
REQ-036 clear asserted at beat 8: m_valid drops the next cycle, busy = 0, no done pulse, and a following start produces a full correct 20-beat frame.
REQ-037 rst_n pulsed low at beat 12: all outputs are 0 immediately (asynchronously), the FSM is in IDLE, and the next start frame is correct.
REQ-038 PAD_X = PAD_Y = 0 build: 6 beats equal the inputs 1..6, with 1-cycle latency and m_eof on beat 6.
